// File: rtl/csr_pkg.sv
// Shared constants and types for the CSR issue unit.
// Optional feature macro: CSR_ILLEGAL_CHECK_EN (address legality check).
package csr_pkg;

    localparam logic [1:0] CS_IDLE  = 2'b00;
    localparam logic [1:0] CS_RW    = 2'b01;
    localparam logic [1:0] CS_ECALL = 2'b10;
    localparam logic [1:0] CS_MRET  = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_RESP
    } fsm_t;

    function automatic logic is_csr_op(logic [2:0] f3);
        return (f3 == F3_RW)  || (f3 == F3_RS)  || (f3 == F3_RC) ||
               (f3 == F3_RWI) || (f3 == F3_RSI) || (f3 == F3_RCI);
    endfunction

    function automatic logic csr_implemented(logic [11:0] a);
        return (a == CSR_MSTATUS) || (a == CSR_MTVEC) ||
               (a == CSR_MEPC)    || (a == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write value for CSR ops; set/clear with rs1=x0 never write.
// Purely combinational.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] new_val,
    output logic            wen
);

    logic [XLEN-1:0] src;

    always_comb begin
        src     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
        new_val = old;
        wen     = 1'b0;
        unique case (funct3[1:0])
            2'b01: begin
                new_val = src;
                wen     = 1'b1;
            end
            2'b10: begin
                new_val = old | src;
                wen     = (rs1_idx != 5'd0);
            end
            2'b11: begin
                new_val = old & ~src;
                wen     = (rs1_idx != 5'd0);
            end
            default: begin
                new_val = old;
                wen     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_issue.sv
// ID-side CSR requester: sequences read/write CSR accesses and trap states.
// Optional feature macro: CSR_ILLEGAL_CHECK_EN.
module csr_issue
    import csr_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid_i,
    output logic                  inst_ready_o,
    input  logic [2:0]            inst_funct3_i,
    input  logic                  inst_is_ecall_i,
    input  logic                  inst_is_mret_i,
    input  logic [CSR_ADDR_W-1:0] inst_csr_addr_i,
    input  logic [4:0]            inst_rs1_idx_i,
    input  logic [XLEN-1:0]       inst_rs1_data_i,
    input  logic [4:0]            inst_rd_idx_i,
    input  logic [XLEN-1:0]       inst_pc_i,
    output logic [1:0]            csr_state_o,
    output logic [CSR_ADDR_W-1:0] csr_r_addr_o,
    output logic                  csr_ren_o,
    input  logic [XLEN-1:0]       csr_r_data_i,
    output logic [CSR_ADDR_W-1:0] csr_w_addr_o,
    output logic                  csr_wen_o,
    output logic [XLEN-1:0]       csr_w_data_o,
    output logic [XLEN-1:0]       csr_pc_o,
    input  logic [XLEN-1:0]       csr_dnpc_i,
    output logic                  done_o,
    output logic                  rd_wen_o,
    output logic [4:0]            rd_idx_o,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic                  illegal_o
);

    fsm_t                  state_q, state_d;
    logic [2:0]            f3_q;
    logic                  ecall_q, trap_q, csr_q, ill_q;
    logic [CSR_ADDR_W-1:0] addr_q;
    logic [4:0]            rs1_idx_q, rd_idx_q;
    logic [XLEN-1:0]       rs1_data_q, pc_q;
    logic [XLEN-1:0]       old_q, new_q, redir_q;
    logic                  wen_q;
    logic [XLEN-1:0]       alu_new;
    logic                  alu_wen;
    logic                  accept, trap_d, op_d, ill_d;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (f3_q),
        .old      (csr_r_data_i),
        .rs1_data (rs1_data_q),
        .rs1_idx  (rs1_idx_q),
        .new_val  (alu_new),
        .wen      (alu_wen)
    );

    assign accept = (state_q == S_IDLE) && inst_valid_i;
    assign trap_d = inst_is_ecall_i || inst_is_mret_i;
    assign op_d   = is_csr_op(inst_funct3_i) && !trap_d;
`ifdef CSR_ILLEGAL_CHECK_EN
    assign ill_d  = op_d && !csr_implemented(12'(inst_csr_addr_i));
`else
    assign ill_d  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            f3_q       <= '0;
            ecall_q    <= 1'b0;
            trap_q     <= 1'b0;
            csr_q      <= 1'b0;
            ill_q      <= 1'b0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            rd_idx_q   <= '0;
            pc_q       <= '0;
            old_q      <= '0;
            new_q      <= '0;
            wen_q      <= 1'b0;
            redir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q       <= inst_funct3_i;
                ecall_q    <= inst_is_ecall_i;
                trap_q     <= trap_d;
                csr_q      <= op_d && !ill_d;
                ill_q      <= ill_d;
                addr_q     <= inst_csr_addr_i;
                rs1_idx_q  <= inst_rs1_idx_i;
                rs1_data_q <= inst_rs1_data_i;
                rd_idx_q   <= inst_rd_idx_i;
                pc_q       <= inst_pc_i;
            end
            if (state_q == S_READ) begin
                old_q <= csr_r_data_i;
                new_q <= alu_new;
                wen_q <= alu_wen;
            end
            if (state_q == S_TRAP) begin
                redir_q <= csr_dnpc_i;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        inst_ready_o     = 1'b0;
        csr_state_o      = CS_IDLE;
        csr_r_addr_o     = '0;
        csr_ren_o        = 1'b0;
        csr_w_addr_o     = '0;
        csr_wen_o        = 1'b0;
        csr_w_data_o     = '0;
        csr_pc_o         = '0;
        done_o           = 1'b0;
        rd_wen_o         = 1'b0;
        rd_idx_o         = '0;
        rd_data_o        = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        illegal_o        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                inst_ready_o = 1'b1;
                if (inst_valid_i) begin
                    if (trap_d)              state_d = S_TRAP;
                    else if (op_d && !ill_d) state_d = S_READ;
                    else                     state_d = S_RESP;
                end
            end
            S_READ: begin
                csr_ren_o    = 1'b1;
                csr_r_addr_o = addr_q;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                csr_state_o  = CS_RW;
                csr_w_addr_o = addr_q;
                csr_w_data_o = new_q;
                csr_wen_o    = wen_q;
                state_d      = S_RESP;
            end
            S_TRAP: begin
                csr_state_o = ecall_q ? CS_ECALL : CS_MRET;
                csr_pc_o    = pc_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                done_o    = 1'b1;
                illegal_o = ill_q;
                if (trap_q) begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = redir_q;
                end else if (csr_q) begin
                    rd_wen_o  = (rd_idx_q != 5'd0);
                    rd_idx_o  = rd_idx_q;
                    rd_data_o = old_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_issue.sv
// Self-checking bench for csr_issue: directed table, reset abort, random ops.
// Honours CSR_ILLEGAL_CHECK_EN for the illegal-address expectations.
module tb_csr_issue;
    import csr_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic        ec;
        logic        mr;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [63:0] pc;
        int          lat;
        logic [63:0] e_old;
        logic [63:0] e_new;
        logic        e_wen;
        logic        e_rdwen;
        logic [1:0]  e_trap;
        logic [63:0] e_redir;
        logic        e_ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [2:0]  inst_funct3_i = '0;
    logic        inst_is_ecall_i = 1'b0;
    logic        inst_is_mret_i = 1'b0;
    logic [11:0] inst_csr_addr_i = '0;
    logic [4:0]  inst_rs1_idx_i = '0;
    logic [63:0] inst_rs1_data_i = '0;
    logic [4:0]  inst_rd_idx_i = '0;
    logic [63:0] inst_pc_i = '0;
    logic [1:0]  csr_state_o;
    logic [11:0] csr_r_addr_o;
    logic        csr_ren_o;
    logic [63:0] csr_r_data_i;
    logic [11:0] csr_w_addr_o;
    logic        csr_wen_o;
    logic [63:0] csr_w_data_o;
    logic [63:0] csr_pc_o;
    logic [63:0] csr_dnpc_i;
    logic        done_o;
    logic        rd_wen_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_data_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_issue dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_funct3_i(inst_funct3_i), .inst_is_ecall_i(inst_is_ecall_i),
        .inst_is_mret_i(inst_is_mret_i), .inst_csr_addr_i(inst_csr_addr_i),
        .inst_rs1_idx_i(inst_rs1_idx_i), .inst_rs1_data_i(inst_rs1_data_i),
        .inst_rd_idx_i(inst_rd_idx_i), .inst_pc_i(inst_pc_i),
        .csr_state_o(csr_state_o), .csr_r_addr_o(csr_r_addr_o),
        .csr_ren_o(csr_ren_o), .csr_r_data_i(csr_r_data_i),
        .csr_w_addr_o(csr_w_addr_o), .csr_wen_o(csr_wen_o),
        .csr_w_data_o(csr_w_data_o), .csr_pc_o(csr_pc_o),
        .csr_dnpc_i(csr_dnpc_i), .done_o(done_o),
        .rd_wen_o(rd_wen_o), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o)
    );

    // Minimal CSR file responding to the DUT
    logic [63:0] f_mstatus = '0, f_mtvec = '0, f_mepc = '0, f_mcause = '0;

    always_comb begin
        csr_r_data_i = '0;
        if (csr_ren_o) begin
            case (csr_r_addr_o)
                CSR_MSTATUS: csr_r_data_i = f_mstatus;
                CSR_MTVEC:   csr_r_data_i = f_mtvec;
                CSR_MEPC:    csr_r_data_i = f_mepc;
                CSR_MCAUSE:  csr_r_data_i = f_mcause;
                default:     csr_r_data_i = '0;
            endcase
        end
        csr_dnpc_i = (csr_state_o == CS_ECALL) ? f_mtvec :
                     (csr_state_o == CS_MRET)  ? f_mepc  : 64'd0;
    end

    always @(posedge clk) begin
        if (csr_state_o == CS_RW && csr_wen_o) begin
            case (csr_w_addr_o)
                CSR_MSTATUS: f_mstatus <= csr_w_data_o;
                CSR_MTVEC:   f_mtvec   <= csr_w_data_o;
                CSR_MEPC:    f_mepc    <= csr_w_data_o;
                CSR_MCAUSE:  f_mcause  <= csr_w_data_o;
                default: ;
            endcase
        end else if (csr_state_o == CS_ECALL) begin
            f_mepc <= csr_pc_o;
        end
    end

    // Reference model: architectural CSR contents keyed by address
    logic [63:0] refm [logic [11:0]];

    function automatic logic [63:0] ref_get(logic [11:0] a);
        return refm.exists(a) ? refm[a] : 64'd0;
    endfunction

    function automatic vec_t predict(vec_t v);
        vec_t r = v;
        logic [63:0] src;
        r.e_old = 0; r.e_new = 0; r.e_wen = 0; r.e_rdwen = 0;
        r.e_trap = 0; r.e_redir = 0; r.e_ill = 0; r.lat = 1;
        if (v.ec) begin
            r.lat = 2; r.e_trap = CS_ECALL;
            r.e_redir = ref_get(CSR_MTVEC);
            refm[CSR_MEPC] = v.pc;
        end else if (v.mr) begin
            r.lat = 2; r.e_trap = CS_MRET;
            r.e_redir = ref_get(CSR_MEPC);
        end else if (v.f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) begin
`ifdef CSR_ILLEGAL_CHECK_EN
            if (!csr_implemented(v.addr)) begin
                r.e_ill = 1;
                return r;
            end
`endif
            r.lat = 3;
            r.e_old = ref_get(v.addr);
            src = (v.f3 inside {3'd5, 3'd6, 3'd7}) ? 64'(v.idx) : v.data;
            if (v.f3 inside {3'd1, 3'd5}) begin
                r.e_new = src; r.e_wen = 1;
            end else if (v.f3 inside {3'd2, 3'd6}) begin
                r.e_new = r.e_old | src; r.e_wen = (v.idx != 0);
            end else begin
                r.e_new = r.e_old & ~src; r.e_wen = (v.idx != 0);
            end
            if (r.e_wen && csr_implemented(v.addr)) refm[v.addr] = r.e_new;
            r.e_rdwen = (v.rd != 0);
        end
        return r;
    endfunction

    function automatic vec_t mk(logic [2:0] f3, logic ec, logic mr,
                                logic [11:0] addr, logic [4:0] idx,
                                logic [63:0] data, logic [4:0] rd,
                                logic [63:0] pc, int lat, logic [63:0] eo,
                                logic [63:0] en, logic ew, logic erw,
                                logic [1:0] et, logic [63:0] er, logic ei);
        vec_t v;
        v.f3 = f3; v.ec = ec; v.mr = mr; v.addr = addr; v.idx = idx;
        v.data = data; v.rd = rd; v.pc = pc; v.lat = lat; v.e_old = eo;
        v.e_new = en; v.e_wen = ew; v.e_rdwen = erw; v.e_trap = et;
        v.e_redir = er; v.e_ill = ei;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        inst_funct3_i = v.f3; inst_is_ecall_i = v.ec; inst_is_mret_i = v.mr;
        inst_csr_addr_i = v.addr; inst_rs1_idx_i = v.idx;
        inst_rs1_data_i = v.data; inst_rd_idx_i = v.rd; inst_pc_i = v.pc;
        inst_valid_i = 1'b1;
    endtask

    task automatic scramble();
        inst_valid_i = 1'b0;
        inst_funct3_i = 3'($urandom); inst_is_ecall_i = 1'($urandom);
        inst_is_mret_i = 1'($urandom); inst_csr_addr_i = 12'($urandom);
        inst_rs1_idx_i = 5'($urandom); inst_rs1_data_i = {$urandom, $urandom};
        inst_rd_idx_i = 5'($urandom); inst_pc_i = {$urandom, $urandom};
    endtask

    task automatic do_op(vec_t v);
        logic csrp, trp, fin;
        csrp = (v.lat == 3);
        trp  = (v.lat == 2);
        @(negedge clk);
        chk("ready_before", inst_ready_o, 1);
        drive(v);
        @(posedge clk);
        #1 scramble();
        for (int c = 1; c <= v.lat + 1; c++) begin
            @(negedge clk);
            fin = (c == v.lat);
            chk("done", done_o, fin);
            chk("ready", inst_ready_o, c > v.lat);
            chk("ren", csr_ren_o, csrp && c == 1);
            chk("r_addr", csr_r_addr_o, (csrp && c == 1) ? v.addr : 12'd0);
            chk("state", csr_state_o, (csrp && c == 2) ? CS_RW :
                                      (trp && c == 1) ? v.e_trap : CS_IDLE);
            chk("wen", csr_wen_o, csrp && c == 2 && v.e_wen);
            chk("w_addr", csr_w_addr_o, (csrp && c == 2) ? v.addr : 12'd0);
            chk("w_data", csr_w_data_o, (csrp && c == 2) ? v.e_new : 64'd0);
            chk("csr_pc", csr_pc_o, (trp && c == 1) ? v.pc : 64'd0);
            chk("rd_wen", rd_wen_o, fin && v.e_rdwen);
            chk("rd_idx", rd_idx_o, (fin && csrp) ? v.rd : 5'd0);
            chk("rd_data", rd_data_o, (fin && csrp) ? v.e_old : 64'd0);
            chk("redir_v", redirect_valid_o, fin && trp);
            chk("redir_pc", redirect_pc_o, (fin && trp) ? v.e_redir : 64'd0);
            chk("illegal", illegal_o, fin && v.e_ill);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_ready"}, inst_ready_o, 1);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_state"}, csr_state_o, 0);
        chk({tag, "_ren"}, csr_ren_o, 0);
        chk({tag, "_wen"}, csr_wen_o, 0);
        chk({tag, "_rdwen"}, rd_wen_o, 0);
        chk({tag, "_redir"}, redirect_valid_o, 0);
        chk({tag, "_illegal"}, illegal_o, 0);
        chk({tag, "_rdata"}, rd_data_o, 0);
    endtask

    vec_t tbl[14];
    vec_t v;
    int   rst_done;
    logic [11:0] alist [5];

    initial begin
        tbl[0]  = mk(3'b001, 0, 0, 12'h305, 1, 64'h8000_0100, 5, 0,
                     3, 0, 64'h8000_0100, 1, 1, 0, 0, 0);
        tbl[1]  = mk(3'b001, 0, 0, 12'h300, 2, 64'ha0000_1800, 0, 0,
                     3, 0, 64'ha0000_1800, 1, 0, 0, 0, 0);
        tbl[2]  = mk(3'b010, 0, 0, 12'h300, 3, 64'h8, 6, 0,
                     3, 64'ha0000_1800, 64'ha0000_1808, 1, 1, 0, 0, 0);
        tbl[3]  = mk(3'b010, 0, 0, 12'h300, 0, 64'hffff, 7, 0,
                     3, 64'ha0000_1808, 64'ha0000_ffff, 0, 1, 0, 0, 0);
        tbl[4]  = mk(3'b001, 0, 0, 12'h342, 4, 64'hb, 8, 0,
                     3, 0, 64'hb, 1, 1, 0, 0, 0);
        tbl[5]  = mk(3'b111, 0, 0, 12'h342, 3, 64'hffff, 9, 0,
                     3, 64'hb, 64'h8, 1, 1, 0, 0, 0);
        tbl[6]  = mk(3'b111, 0, 0, 12'h342, 3, 0, 0, 0,
                     3, 64'h8, 64'h8, 1, 0, 0, 0, 0);
        tbl[7]  = mk(3'b000, 1, 0, 0, 0, 0, 0, 64'h8000_0040,
                     2, 0, 0, 0, 0, CS_ECALL, 64'h8000_0100, 0);
        tbl[8]  = mk(3'b000, 0, 1, 0, 0, 0, 0, 64'h8000_0044,
                     2, 0, 0, 0, 0, CS_MRET, 64'h8000_0040, 0);
        tbl[9]  = mk(3'b001, 1, 1, 12'h300, 1, 1, 1, 64'h8000_0080,
                     2, 0, 0, 0, 0, CS_ECALL, 64'h8000_0100, 0);
        tbl[10] = mk(3'b000, 0, 0, 12'h300, 1, 1, 10, 0,
                     1, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(3'b100, 0, 0, 12'h305, 1, 1, 11, 0,
                     1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(3'b110, 0, 0, 12'h305, 5'h10, 0, 3, 0,
                     3, 64'h8000_0100, 64'h8000_0110, 1, 1, 0, 0, 0);
`ifdef CSR_ILLEGAL_CHECK_EN
        tbl[13] = mk(3'b001, 0, 0, 12'hb00, 4, 64'h5, 4, 0,
                     1, 0, 0, 0, 0, 0, 0, 1);
`else
        tbl[13] = mk(3'b001, 0, 0, 12'hb00, 4, 64'h5, 4, 0,
                     3, 0, 64'h5, 1, 1, 0, 0, 0);
`endif
        alist = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hb00};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_rdidx", rd_idx_o, 0);
        chk("reset_redir_pc", redirect_pc_o, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            v = predict(tbl[i]);
            do_op(tbl[i]);
        end

        // Reset during WRITE must abort the pending mepc write
        @(negedge clk);
        drive(mk(3'b001, 0, 0, 12'h341, 1, 64'h1234, 2, 0,
                 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 scramble();
        @(negedge clk);
        chk("abort_read", csr_ren_o, 1);
        @(negedge clk);
        chk("abort_in_write", csr_state_o, CS_RW);
        rst_n = 1'b0;
        #1 chk_idle("abort");
        rst_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o) rst_done++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", rst_done, 0);
        chk_idle("after_abort");
        v = predict(mk(3'b010, 0, 0, 12'h341, 0, 64'hff, 3, 0,
                       0, 0, 0, 0, 0, 0, 0, 0));
        chk("abort_mepc_kept", v.e_old, 64'h8000_0080);
        do_op(v);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 9);
            v = mk(3'b001, 0, 0, alist[$urandom_range(0, 4)],
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   {$urandom, $urandom}, 5'($urandom),
                   {$urandom, $urandom} & ~64'h3, 0, 0, 0, 0, 0, 0, 0, 0);
            case (k)
                0: v.ec = 1;
                1: v.mr = 1;
                2: begin v.ec = 1; v.mr = 1; end
                3: v.f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b100;
                default: begin
                    v.f3 = 3'($urandom_range(1, 6));
                    if (v.f3 == 3'b100) v.f3 = 3'b111;
                end
            endcase
            v = predict(v);
            do_op(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_issue.md
Name: csr_issue

Overview:
- ID-side requester for the machine-mode CSR register file. It is the initiator end of the CSR request/response interface.
- Accepts one decoded CSR/ECALL/MRET instruction per valid/ready handshake and sequences read-then-write CSR accesses. It also issues trap entry/return states to the CSR file.
- Returns the rd writeback value or the redirect PC to the pipeline. The pipeline holds its stall while inst_ready_o is low.

Parameters:
- XLEN, 64, data width of CSR and GPR values.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_valid_i  in  1  decoded instruction valid
- inst_ready_o  out  1  block idle, instruction accepted when valid&&ready
- inst_funct3_i  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- inst_is_ecall_i  in  1  instruction is ECALL
- inst_is_mret_i  in  1  instruction is MRET
- inst_csr_addr_i  in  12  CSR address
- inst_rs1_idx_i  in  5  rs1 index; also the zimm field for immediate ops
- inst_rs1_data_i  in  XLEN  rs1 value
- inst_rd_idx_i  in  5  destination register
- inst_pc_i  in  XLEN  instruction PC
- csr_state_o  out  2  00 IDLE, 01 RW, 10 ECALL, 11 MRET
- csr_r_addr_o  out  12  CSR read address
- csr_ren_o  out  1  CSR read enable
- csr_r_data_i  in  XLEN  combinational CSR read data
- csr_w_addr_o  out  12  CSR write address
- csr_wen_o  out  1  CSR write enable; written at clock edge while csr_state_o==RW
- csr_w_data_o  out  XLEN  CSR write data
- csr_pc_o  out  XLEN  PC saved to mepc on ECALL
- csr_dnpc_i  in  XLEN  trap target from CSR file (mtvec on ECALL, mepc on MRET)
- done_o  out  1  one-cycle completion pulse
- rd_wen_o  out  1  GPR write enable, qualified with done_o
- rd_idx_o  out  5  GPR destination
- rd_data_o  out  XLEN  old CSR value
- redirect_valid_o  out  1  PC redirect, qualified with done_o
- redirect_pc_o  out  XLEN  redirect target
- illegal_o  out  1  unimplemented CSR access (optional feature)

Behaviour:
- Reset: async, FSM goes to IDLE. All outputs are 0 except inst_ready_o=1. All captured registers are cleared.
- FSM states: IDLE, READ, WRITE, TRAP, RESP. inst_ready_o=1 only in IDLE.
- IDLE, on acceptance: all inputs are latched. Priority is ecall > mret > CSR op.
  - ECALL or MRET → TRAP.
  - funct3 in the CSR set → READ.
  - Any other funct3 → RESP with no side effects.
- READ (1 cycle):
  - csr_ren_o=1, csr_r_addr_o=addr_q, csr_state_o=IDLE.
  - csr_r_data_i is captured into old_q.
  - src = zero-extended rs1_idx for immediate ops, else rs1_data.
  - new_q = src (RW/RWI), old|src (RS/RSI), old&~src (RC/RCI).
  - → WRITE.
- WRITE (1 cycle):
  - csr_state_o=RW, csr_w_addr_o=addr_q, csr_w_data_o=new_q.
  - csr_wen_o=1, except for RS/RC/RSI/RCI with rs1_idx==0, where csr_wen_o=0.
  - → RESP.
- TRAP (1 cycle):
  - csr_state_o=ECALL or MRET, csr_pc_o=pc_q.
  - csr_dnpc_i is captured into redirect_pc_q.
  - → RESP.
- RESP (1 cycle), done_o=1:
  - CSR op: rd_wen_o = (rd_idx_q!=0), rd_data_o=old_q.
  - Trap: redirect_valid_o=1, redirect_pc_o=redirect_pc_q.
  - → IDLE.
- Latency from the acceptance edge: CSR op done at cycle 3, trap done at cycle 2, unknown funct3 done at cycle 1. No back-to-back acceptance.
- Outside their active state, csr_* outputs are 0.
- Reset asserted mid-operation: pending write or trap is aborted, no done_o pulse.
- Inputs are ignored while not in IDLE.

Optional Feature:
- Macro: CSR_ILLEGAL_CHECK_EN.
- Defined: implemented set is 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
  - A CSR op to any other address goes IDLE→RESP directly: no csr_ren_o, no csr_wen_o, rd_wen_o=0, illegal_o=1 with done_o.
- Undefined: illegal_o tied 0. All addresses are sequenced normally; the file returns 0 and ignores the write.

Decomposition:
- Shared package csr_pkg:
  - csr_state codes (IDLE/RW/ECALL/MRET)
  - CSR address constants
  - funct3 op codes
  - FSM state enum
- Sub-module csr_alu, combinational: (funct3, old, rs1_data, rs1_idx) → new value and write enable.

Test Plan:
- CSRRW 0x305, rs1_data=0x8000_0100, rd=5, mtvec=0 → WRITE: wen=1, w_data=0x8000_0100. RESP: rd_wen=1, rd_idx=5, rd_data=0. Done at cycle 3.
- CSRRS 0x300, old=0xa00001800, rs1_data=0x8 → w_data=0xa00001808. Then CSRRS with rs1_idx=0 → wen=0, rd_data=0xa00001808.
- CSRRCI 0x342, old=0xb, zimm=3 → w_data=0x8. Same op with rd=0 → rd_wen=0.
- ECALL pc=0x8000_0040, mtvec=0x8000_0100 → TRAP: state=10, csr_pc=0x8000_0040. RESP: redirect 0x8000_0100. Then MRET → state=11, redirect=0x8000_0040.
- ECALL and MRET asserted together → ECALL path taken. Reset pulsed during WRITE → no done_o, FSM in IDLE, inst_ready_o=1.
- With CSR_ILLEGAL_CHECK_EN: CSRRW 0xb00 → illegal_o=1 at cycle 1, csr_ren=csr_wen=0.
